// File: rtl/fft_burst_pkg.sv
// fft_burst_pkg: shared FSM states and default burst geometry
package fft_burst_pkg;
  localparam int BURST_LEN_DEF = 32;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/fft_burst_capture_buffer.sv
// burst_buffer: unreset sample store, sync write, combinational read
module burst_buffer #(
  parameter int BURST_LEN = 32,
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CNT_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [BURST_LEN];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fft_burst_capture.sv
// fft_burst_capture: capture one window-framed burst, check its length, replay it on a stream
module fft_burst_capture
  import fft_burst_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int CNT_W = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              burst_done,
  output logic              len_err
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, waddr;
  logic armed_q, armed_d, len_err_q, len_err_d, done_q, done_d, first_q, first_d, we;
  burst_buffer #(.BURST_LEN(BURST_LEN), .DATA_W(DATA_W)) u_buf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(in_data), .raddr(rd_idx_q), .rdata(out_data)
  );
  assign out_valid = state_q == DRAIN;
  assign out_last = out_valid && rd_idx_q == LAST;
  assign busy = state_q != IDLE;
  assign burst_done = done_q;
  assign len_err = len_err_q;
  always_comb begin
    state_d = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    armed_d = in_valid ? armed_q : 1'b1;
    len_err_d = len_err_q;
    done_d = 1'b0;
    we = 1'b0;
    waddr = wr_idx_q;
    if (state_q == IDLE && in_valid && armed_q) begin
      we = 1'b1;
      waddr = '0;
      wr_idx_d = CNT_W'(1);
      armed_d = 1'b0;
      state_d = CAPTURE;
    end
    if (state_q == CAPTURE) begin
      we = in_valid;
      wr_idx_d = !in_valid ? '0 : wr_idx_q == LAST ? wr_idx_q : wr_idx_q + CNT_W'(1);
      rd_idx_d = '0;
      len_err_d = len_err_q || !in_valid;
      state_d = !in_valid ? IDLE : wr_idx_q == LAST ? DRAIN : CAPTURE;
    end
    if (state_q == DRAIN) begin
      len_err_d = len_err_q || (first_q && in_valid);
      if (out_ready) begin
        rd_idx_d = rd_idx_q == LAST ? '0 : rd_idx_q + CNT_W'(1);
        done_d = rd_idx_q == LAST;
        state_d = rd_idx_q == LAST ? IDLE : DRAIN;
      end
    end
    first_d = state_q == CAPTURE && state_d == DRAIN;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      armed_q <= 1'b1;
      len_err_q <= 1'b0;
      done_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      armed_q <= armed_d;
      len_err_q <= len_err_d;
      done_q <= done_d;
      first_q <= first_d;
    end
endmodule

// File: tb/tb_fft_burst_capture.sv
// tb_fft_burst_capture: table-driven burst scenarios with a replay scoreboard
module tb_fft_burst_capture;
  localparam int BL = 32;
  localparam int DW = 16;
  typedef struct {
    bit rst;
    int n_in;
    bit stall;
    bit exp_err;
    int exp_outs;
    int exp_drain;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic out_valid, out_last, busy, burst_done, len_err;
  logic [DW-1:0] out_data;
  logic [DW-1:0] q[$];
  logic [DW-1:0] prev_data, exp_val;
  bit stall = 1'b0, exp_done = 1'b0, prev_stall = 1'b0;
  int checks = 0, failures = 0, outs = 0, done_cnt = 0, vcyc = 0, last_drain = 0, vcnt = 0;
  vec_t vec[6];
  fft_burst_capture #(.BURST_LEN(BL), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .burst_done(burst_done), .len_err(len_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      out_ready = stall ? (vcnt % 2 == 0) : 1'b1;
      vcnt++;
    end else begin
      vcnt = 0;
      out_ready = !stall;
    end
  end
  always @(negedge clk) begin
    if (!rstn) begin
      exp_done = 1'b0;
      prev_stall = 1'b0;
      vcyc = 0;
    end else begin
      check("burst_done", burst_done, exp_done);
      if (burst_done) begin
        last_drain = vcyc;
        vcyc = 0;
        done_cnt++;
      end
      exp_done = 1'b0;
      if (out_valid) begin
        vcyc++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=none", out_data);
        end else begin
          check("out_last", out_last, q.size() == 1);
          if (prev_stall) check("stall_hold", out_data, prev_data);
          if (out_ready) begin
            exp_val = q.pop_front();
            check("out_data", out_data, exp_val);
            outs++;
            exp_done = q.size() == 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    in_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask
  task automatic send_window(input int n, input int base, input bit keep);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data = DW'(base + i);
      if (keep && i < BL) q.push_back(DW'(base + i));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done(input int snap);
    int t = 0;
    while (done_cnt == snap && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", done_cnt != snap, 1);
  endtask
  initial begin
    int osnap, dsnap, t;
    vec[0] = '{1, 32, 0, 0, 32, 32};
    vec[1] = '{1, 32, 1, 0, 32, 63};
    vec[2] = '{1, 10, 0, 1, 0, 0};
    vec[3] = '{0, 32, 0, 1, 32, 32};
    vec[4] = '{1, 40, 0, 1, 32, 32};
    vec[5] = '{1, 70, 0, 1, 32, 32};
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_out_last", out_last, 0);
    for (int v = 0; v < 6; v++) begin
      if (vec[v].rst) do_reset();
      stall = vec[v].stall;
      osnap = outs;
      dsnap = done_cnt;
      send_window(vec[v].n_in, v * 64, vec[v].n_in >= BL);
      if (vec[v].exp_outs > 0) wait_done(dsnap);
      repeat (4) @(posedge clk);
      #2;
      check($sformatf("v%0d_idle", v), busy, 0);
      check($sformatf("v%0d_outs", v), outs - osnap, vec[v].exp_outs);
      check($sformatf("v%0d_len_err", v), len_err, vec[v].exp_err);
      check($sformatf("v%0d_q_empty", v), q.size(), 0);
      if (vec[v].exp_outs > 0) check($sformatf("v%0d_drain", v), last_drain, vec[v].exp_drain);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    q.delete();
    in_valid = 1'b1;
    in_data = DW'(16'h500);
    repeat (2) @(posedge clk);
    #1;
    osnap = outs;
    dsnap = done_cnt;
    rstn = 1'b1;
    q.push_back(DW'(16'h500));
    for (int i = 1; i < BL; i++) begin
      @(posedge clk);
      #1;
      in_data = DW'(16'h500 + i);
      q.push_back(DW'(16'h500 + i));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(dsnap);
    repeat (3) @(posedge clk);
    #2;
    check("hot_rst_outs", outs - osnap, BL);
    check("hot_rst_len_err", len_err, 0);
    check("hot_rst_q_empty", q.size(), 0);
    osnap = outs;
    send_window(BL, 16'h600, 1'b1);
    t = 0;
    while (outs - osnap < 12 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("mid_idx", outs - osnap, 12);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", burst_done, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    osnap = outs;
    dsnap = done_cnt;
    send_window(BL, 16'h700, 1'b1);
    wait_done(dsnap);
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_outs", outs - osnap, BL);
    check("post_rst_q_empty", q.size(), 0);
    check("post_rst_len_err", len_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_burst_capture.md
Name: fft_burst_capture

Overview:
- Receive-side counterpart of the one-shot sample-window pulse generator that frames FFT input bursts.
- Consumes a window-valid level plus data, captures exactly BURST_LEN samples into a local buffer, and checks window length.
- Replays the captured burst downstream on a valid/ready stream with a last marker.
- Sits between the windowed ADC/sample source and the FFT core input.

Parameters:
- BURST_LEN, 32, samples per burst; must be >= 2; any integer, not restricted to powers of 2.
- DATA_W, 16, sample width in bits.
- CNT_W, $clog2(BURST_LEN), derived localparam; index width, holds 0..BURST_LEN-1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  window level from the pulse generator; high means in_data is a sample.
- in_data  in  DATA_W  sample, qualified by in_valid.
- out_valid  out  1  replay sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  replay sample.
- out_last  out  1  high with the final sample (index BURST_LEN-1).
- busy  out  1  high in CAPTURE or DRAIN.
- burst_done  out  1  one-cycle pulse after the final replay handshake.
- len_err  out  1  sticky window-length error; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_idx = rd_idx = 0; armed = 1. Buffer contents are don't-care and are not cleared.
- armed: cleared when a capture starts; set on any cycle with in_valid == 0. A window must fall before a new one can start.
- IDLE: if in_valid && armed, write in_data to buf[0], set wr_idx = 1, go to CAPTURE. This sample is accepted in the same cycle.
- CAPTURE:
  - in_valid == 1: write buf[wr_idx] and increment wr_idx. If wr_idx == BURST_LEN-1, go to DRAIN with rd_idx = 0.
  - in_valid == 0 (short window): set len_err, discard the partial burst, go to IDLE. No output is produced.
- DRAIN:
  - out_valid = 1; out_data = buf[rd_idx]; out_last = (rd_idx == BURST_LEN-1).
  - On out_valid && out_ready, rd_idx increments. On the last handshake, go to IDLE and pulse burst_done in the next cycle.
  - out_valid and out_data stay stable while out_ready is low.
- Latency: first out_valid is asserted the cycle after the last sample is written. With out_ready held high, the burst drains in BURST_LEN cycles.
- Long window: in_valid still high in the first DRAIN cycle sets len_err. Extra samples are ignored and never written. armed stays 0, so the window tail cannot start a new capture.
- A new window arriving during DRAIN is ignored except for the long-window check above; it sets armed when it falls.
- Simultaneous events:
  - burst_done asserts in the same cycle the FSM sits in IDLE. A capture may start in that cycle if armed.
  - len_err set and clear never conflict, because len_err is cleared only by reset.
- Reset mid-operation: immediate return to reset values. Any in-flight burst is dropped, and out_valid drops asynchronously.
- Width rules: index compares use CNT_W bits. No arithmetic on data; samples pass through bit-exact.

Decomposition:
- Shared package fft_burst_pkg:
  - state enum: IDLE, CAPTURE, DRAIN.
  - default BURST_LEN and DATA_W constants, shared with the pulse generator instance.
- Sub-module burst_buffer:
  - BURST_LEN x DATA_W register array.
  - One synchronous write port (we, waddr, wdata); one combinational read port (raddr, rdata).
  - No reset on storage.
- Top level holds the FSM, indices, armed flag, and flags.

Test Plan:
1. Reset, then in_valid high for exactly 32 cycles with in_data = 0..31, out_ready = 1 -> out_valid for 32 consecutive cycles starting the cycle after the last input. Data 0..31 in order; out_last only on 31; burst_done one cycle later; len_err = 0.
2. Same burst with out_ready toggling 1,0,1,0 -> every value 0..31 delivered exactly once. out_data is held stable on stalls; drain takes 63 cycles.
3. in_valid high for only 10 cycles -> len_err = 1; no out_valid; FSM back in IDLE. A following 32-sample window (after in_valid goes low) replays correctly.
4. in_valid high for 40 cycles -> first 32 samples replayed, len_err = 1. Samples 32..39 are never output, and no second capture starts until in_valid falls and rises again.
5. in_valid already high across reset release -> capture starts on the first post-reset cycle, because armed = 1 at reset.
6. Reset asserted at DRAIN index 12 -> out_valid, busy, and burst_done go to 0 immediately. After release, a fresh 32-sample window replays from index 0.
